m_interrupt_ctrl: RTL and testbench
===================================

Name: m_interrupt_ctrl

Overview:
- Machine-mode interrupt source and arbiter; sits directly upstream of the CSR array.
- Holds memory-mapped mtime/mtimecmp/msip registers and synchronises the external interrupt pin.
- Gates each pending source with the CSR enables (MEIE/MTIE/MSIE, mstatus.MIE).
- Issues a single-cycle g_interrupt request with priority level, then blocks further requests until mret retires.

Parameters:
- TICK_DIV, 1, number of clk cycles per mtime increment; must be >= 1.
- EXT_SYNC_STAGES, 2, number of flops in the external interrupt synchroniser; must be >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ext_int_in  in  1  asynchronous level external interrupt, active high
- csr_rmie  in  1  mstatus.MIE from CSR array
- csr_meie  in  1  mie.MEIE
- csr_mtie  in  1  mie.MTIE
- csr_msie  in  1  mie.MSIE
- cmd_mret_ex  in  1  mret in EX stage
- stall  in  1  pipeline stall; the request is not issued while high
- io_we  in  1  register write strobe
- io_re  in  1  register read strobe
- io_adr  in  3  word address: 0 mtime_lo, 1 mtime_hi, 2 mtimecmp_lo, 3 mtimecmp_hi, 4 msip; 5-7 reserved
- io_wdata  in  32  write data
- io_rdata  out  32  read data, registered
- g_interrupt  out  1  one-cycle interrupt request to the CSR array
- g_interrupt_priv  out  2  privilege of the request; always 2'b11
- g_current_priv  out  2  current privilege; always 2'b11
- int_code  out  6  cause of the last issued request: 11 external, 3 software, 7 timer
- mip_bits  out  3  raw pending bits {MEIP, MTIP, MSIP}, before enable gating

Behaviour:
- Reset values:
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0.
  - io_rdata = 0, g_interrupt = 0, int_code = 0, state = IDLE, prescaler = 0.
  - Synchroniser flops = 0.
  - g_interrupt_priv and g_current_priv are constant 2'b11.
- Timer:
  - Prescaler counts 0..TICK_DIV-1; tick = (prescaler == TICK_DIV-1).
  - mtime increments by 1 on tick as a 64-bit counter and wraps from all-ones to 0.
  - Carry into hi = tick & (lo == 32'hFFFF_FFFF).
- Register writes:
  - A write to a mtime half replaces that half that cycle.
  - The other half still takes its normal increment or carry, computed from the old lo.
  - msip write keeps only io_wdata[0]; upper bits read as 0.
  - Writes to reserved addresses are ignored.
- Register reads:
  - io_rdata is updated the cycle after io_re; it holds its value when io_re is low.
  - Reserved addresses read 0.
  - Read and write to the same address in one cycle returns the old value.
- Pending bits:
  - MEIP = ext_int_in after EXT_SYNC_STAGES flops (level).
  - MTIP = (mtime >= mtimecmp), 64-bit unsigned compare, evaluated on current register values.
  - MSIP = msip.
- Gated pending:
  - pe = MEIP & csr_meie & csr_rmie.
  - ps = MSIP & csr_msie & csr_rmie.
  - pt = MTIP & csr_mtie & csr_rmie.
  - Priority: external > software > timer.
- FSM states IDLE, WAIT_MRET:
  - IDLE to WAIT_MRET: any gated pending & ~stall & ~cmd_mret_ex. That same cycle g_interrupt = 1 (combinational from state) and int_code is registered with the winning cause.
  - IDLE, stall high: no request; re-evaluate next cycle. The request is dropped if pending clears meanwhile.
  - WAIT_MRET: g_interrupt = 0; pending is ignored.
  - WAIT_MRET to IDLE: cmd_mret_ex & ~stall.
  - mret while in IDLE: stay in IDLE.
- g_interrupt is never high for two consecutive cycles and never high while stall = 1.
- Interrupts are level-sensitive: a source still pending after mret re-requests once it is gated on again; the earliest request is the cycle after the mret cycle.
- Reset asserted mid-operation returns everything to reset values immediately; any in-flight request is lost.

Test Plan:
- Timer request: TICK_DIV=1; write mtimecmp_hi=0, mtimecmp_lo=10; MTIE=1, MIE=1 -> g_interrupt pulses exactly once, in the cycle mtime reaches 10; int_code=7; no further pulse until mret.
- Carry and write collision: set mtime=0x0000_0000_FFFF_FFFF, then write mtime_lo=5 on the carry tick -> next cycle mtime_hi=1, mtime_lo=5. Read mtime_hi -> io_rdata=1 one cycle later.
- Priority: ext_int_in=1, msip=1 and timer pending together, all enabled -> first request int_code=11; after mret with ext dropped -> next request int_code=3.
- Stall hold-off: source pending with stall held 4 cycles -> g_interrupt=0 throughout; pulse on the first cycle stall=0.
- Gating: MIE=0 with all sources pending -> no request and mip_bits=3'b111. Set MIE=1 -> request the next cycle.
- Reset mid-wait: reset asserted in WAIT_MRET -> state IDLE, mtimecmp all-ones, g_interrupt=0, io_rdata=0 at once.

Source files
------------

// File: rtl/m_interrupt_ctrl.sv
// Machine-mode interrupt source and arbiter: mtime/mtimecmp/msip registers,
// external pin synchroniser, enable gating and a one-shot request FSM.
module m_interrupt_ctrl #(
    parameter int TICK_DIV        = 1,
    parameter int EXT_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ext_int_in,
    input  logic        csr_rmie,
    input  logic        csr_meie,
    input  logic        csr_mtie,
    input  logic        csr_msie,
    input  logic        cmd_mret_ex,
    input  logic        stall,
    input  logic        io_we,
    input  logic        io_re,
    input  logic [2:0]  io_adr,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    output logic        g_interrupt,
    output logic [1:0]  g_interrupt_priv,
    output logic [1:0]  g_current_priv,
    output logic [5:0]  int_code,
    output logic [2:0]  mip_bits
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] WAIT_MRET = 1'b1;

    logic [PW-1:0]              prescaler;
    logic                       tick;
    logic                       carry;
    logic [31:0]                mtime_lo;
    logic [31:0]                mtime_hi;
    logic [63:0]                mtimecmp;
    logic                       msip;
    logic [EXT_SYNC_STAGES-1:0] ext_sync;
    logic [0:0]                 state;
    logic                       meip;
    logic                       mtip;
    logic                       pe;
    logic                       ps;
    logic                       pt;
    logic                       any_pend;
    logic [5:0]                 cause;
    logic [31:0]                rd_mux;

    assign tick  = (prescaler == TICK_MAX);
    assign carry = tick & (mtime_lo == 32'hFFFF_FFFF);

    assign meip = ext_sync[EXT_SYNC_STAGES-1];
    assign mtip = ({mtime_hi, mtime_lo} >= mtimecmp);

    assign pe       = meip & csr_meie & csr_rmie;
    assign ps       = msip & csr_msie & csr_rmie;
    assign pt       = mtip & csr_mtie & csr_rmie;
    assign any_pend = pe | ps | pt;

    assign mip_bits         = {meip, mtip, msip};
    assign g_interrupt_priv = 2'b11;
    assign g_current_priv   = 2'b11;

    assign g_interrupt = (state == IDLE) & any_pend & ~stall & ~cmd_mret_ex;

    // External has highest priority, then software, then timer.
    always_comb begin
        cause = 6'd0;
        if (pe) begin
            cause = 6'd11;
        end else if (ps) begin
            cause = 6'd3;
        end else if (pt) begin
            cause = 6'd7;
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (io_adr)
            3'd0:    rd_mux = mtime_lo;
            3'd1:    rd_mux = mtime_hi;
            3'd2:    rd_mux = mtimecmp[31:0];
            3'd3:    rd_mux = mtimecmp[63:32];
            3'd4:    rd_mux = {31'd0, msip};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
        end
    end

    // A write to one mtime half still lets the other half count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_lo <= 32'd0;
            mtime_hi <= 32'd0;
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip     <= 1'b0;
        end else begin
            if (io_we && io_adr == 3'd0) begin
                mtime_lo <= io_wdata;
            end else begin
                mtime_lo <= mtime_lo + {31'd0, tick};
            end
            if (io_we && io_adr == 3'd1) begin
                mtime_hi <= io_wdata;
            end else begin
                mtime_hi <= mtime_hi + {31'd0, carry};
            end
            if (io_we && io_adr == 3'd2) begin
                mtimecmp[31:0] <= io_wdata;
            end
            if (io_we && io_adr == 3'd3) begin
                mtimecmp[63:32] <= io_wdata;
            end
            if (io_we && io_adr == 3'd4) begin
                msip <= io_wdata[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_sync <= '0;
        end else begin
            ext_sync <= {ext_sync[EXT_SYNC_STAGES-2:0], ext_int_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_rdata <= 32'd0;
        end else if (io_re) begin
            io_rdata <= rd_mux;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            int_code <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (g_interrupt) begin
                        state    <= WAIT_MRET;
                        int_code <= cause;
                    end
                end
                default: begin
                    if (cmd_mret_ex && !stall) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_interrupt_ctrl.sv
// Bench for m_interrupt_ctrl: directed scenarios then random traffic,
// checked against a behavioural model of the timer, registers and requests.
module tb_m_interrupt_ctrl;

    localparam int TICK_DIV = 1;
    localparam int SYNC     = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ext_int_in;
    logic        csr_rmie;
    logic        csr_meie;
    logic        csr_mtie;
    logic        csr_msie;
    logic        cmd_mret_ex;
    logic        stall;
    logic        io_we;
    logic        io_re;
    logic [2:0]  io_adr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        g_interrupt;
    logic [1:0]  g_interrupt_priv;
    logic [1:0]  g_current_priv;
    logic [5:0]  int_code;
    logic [2:0]  mip_bits;

    always #5 clk = ~clk;

    m_interrupt_ctrl #(
        .TICK_DIV        (TICK_DIV),
        .EXT_SYNC_STAGES (SYNC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ext_int_in       (ext_int_in),
        .csr_rmie         (csr_rmie),
        .csr_meie         (csr_meie),
        .csr_mtie         (csr_mtie),
        .csr_msie         (csr_msie),
        .cmd_mret_ex      (cmd_mret_ex),
        .stall            (stall),
        .io_we            (io_we),
        .io_re            (io_re),
        .io_adr           (io_adr),
        .io_wdata         (io_wdata),
        .io_rdata         (io_rdata),
        .g_interrupt      (g_interrupt),
        .g_interrupt_priv (g_interrupt_priv),
        .g_current_priv   (g_current_priv),
        .int_code         (int_code),
        .mip_bits         (mip_bits)
    );

    // Reference model state
    logic [63:0] m_time;
    logic [63:0] m_cmp;
    logic        m_msip;
    int          m_presc;
    logic        m_busy;
    logic [5:0]  m_code;
    logic [31:0] m_rdata;
    bit          ext_q[$];

    int   n_tests = 0;
    int   n_fail  = 0;
    logic last_gi;
    int   pulses;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_time  = 64'd0;
        m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
        m_msip  = 1'b0;
        m_presc = 0;
        m_busy  = 1'b0;
        m_code  = 6'd0;
        m_rdata = 32'd0;
        ext_q.delete();
        repeat (SYNC) ext_q.push_back(1'b0);
    endtask

    function automatic logic [31:0] model_reg(input logic [2:0] a);
        case (a)
            3'd0:    return m_time[31:0];
            3'd1:    return m_time[63:32];
            3'd2:    return m_cmp[31:0];
            3'd3:    return m_cmp[63:32];
            3'd4:    return {31'd0, m_msip};
            default: return 32'd0;
        endcase
    endfunction

    // One clock: check combinational outputs mid-cycle, advance the model
    // on the edge, then check registered outputs just after it.
    task automatic cyc();
        logic        meip, mtip, pe, ps, pt, gi, tk;
        logic [5:0]  c;
        logic [63:0] inc;
        @(negedge clk);
        meip = ext_q[0];
        mtip = (m_time >= m_cmp);
        pe   = meip & csr_meie & csr_rmie;
        ps   = m_msip & csr_msie & csr_rmie;
        pt   = mtip & csr_mtie & csr_rmie;
        c    = pe ? 6'd11 : (ps ? 6'd3 : (pt ? 6'd7 : 6'd0));
        gi   = !m_busy && (pe || ps || pt) && !stall && !cmd_mret_ex;
        check("mip_bits", mip_bits, {meip, mtip, m_msip});
        check("g_interrupt", g_interrupt, gi);
        last_gi = g_interrupt;
        @(posedge clk);
        if (io_re) m_rdata = model_reg(io_adr);
        tk      = (m_presc == TICK_DIV - 1);
        m_presc = tk ? 0 : m_presc + 1;
        inc     = m_time + 64'(tk);
        m_time  = inc;
        if (io_we) begin
            case (io_adr)
                3'd0:    m_time = {inc[63:32], io_wdata};
                3'd1:    m_time = {io_wdata, inc[31:0]};
                3'd2:    m_cmp[31:0] = io_wdata;
                3'd3:    m_cmp[63:32] = io_wdata;
                3'd4:    m_msip = io_wdata[0];
                default: ;
            endcase
        end
        if (gi) begin
            m_busy = 1'b1;
            m_code = c;
        end else if (m_busy && cmd_mret_ex && !stall) begin
            m_busy = 1'b0;
        end
        ext_q.push_back(ext_int_in);
        void'(ext_q.pop_front());
        #1;
        check("io_rdata", io_rdata, m_rdata);
        check("int_code", int_code, m_code);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        io_we    = 1'b1;
        io_adr   = a;
        io_wdata = d;
        cyc();
        io_we    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        io_re  = 1'b1;
        io_adr = a;
        cyc();
        io_re  = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        ext_int_in  = 1'b0;
        csr_rmie    = 1'b0;
        csr_meie    = 1'b0;
        csr_mtie    = 1'b0;
        csr_msie    = 1'b0;
        cmd_mret_ex = 1'b0;
        stall       = 1'b0;
        io_we       = 1'b0;
        io_re       = 1'b0;
        io_adr      = 3'd0;
        io_wdata    = 32'd0;
        last_gi     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", io_rdata, 0);
        check("rst_gi", g_interrupt, 0);
        check("rst_code", int_code, 0);
        check("rst_mip", mip_bits, 0);
        check("int_priv", g_interrupt_priv, 2'b11);
        check("cur_priv", g_current_priv, 2'b11);
        rst_n = 1'b1;

        // Timer request at mtime == 10
        wr(3'd2, 32'd10);
        wr(3'd3, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd0, 32'd0);
        csr_rmie = 1'b1;
        csr_mtie = 1'b1;
        io_re    = 1'b1;
        io_adr   = 3'd0;
        pulses   = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (last_gi) begin
                pulses++;
                check("timer_at_10", io_rdata, 10);
                check("timer_code", int_code, 7);
            end
        end
        check("timer_pulses", pulses, 1);
        io_re       = 1'b0;
        csr_mtie    = 1'b0;
        cmd_mret_ex = 1'b1;
        cyc();
        cmd_mret_ex = 1'b0;

        // Carry into hi with a colliding lo write
        wr(3'd1, 32'd0);
        wr(3'd0, 32'hFFFF_FFFE);
        cyc();
        wr(3'd0, 32'd5);
        rd(3'd1);
        check("carry_hi", io_rdata, 1);
        rd(3'd0);
        check("lo_after_write", io_rdata, 6);

        // Gating, then priority ext > sw
        csr_rmie   = 1'b0;
        csr_meie   = 1'b1;
        csr_msie   = 1'b1;
        csr_mtie   = 1'b1;
        ext_int_in = 1'b1;
        wr(3'd4, 32'hFFFF_FFFF);
        rd(3'd4);
        check("msip_read", io_rdata, 1);
        repeat (3) cyc();
        check("gated_mip", mip_bits, 3'b111);
        check("gated_no_req", last_gi, 0);
        csr_rmie = 1'b1;
        cyc();
        check("mie_on_req", last_gi, 1);
        check("prio_ext", int_code, 11);
        ext_int_in = 1'b0;
        repeat (3) cyc();
        cmd_mret_ex = 1'b1;
        cyc();
        check("mret_cycle_no_req", last_gi, 0);
        cmd_mret_ex = 1'b0;
        cyc();
        check("prio_sw_req", last_gi, 1);
        check("prio_sw", int_code, 3);

        // Stall hold-off
        cmd_mret_ex = 1'b1;
        cyc();
        cmd_mret_ex = 1'b0;
        stall       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("stall_hold", last_gi, 0);
        end
        stall = 1'b0;
        cyc();
        check("stall_release", last_gi, 1);
        check("stall_code", int_code, 3);

        // Reset while waiting for mret
        rd(3'd2);
        check("cmp_lo_read", io_rdata, 10);
        rst_n = 1'b0;
        #1;
        check("mid_rst_gi", g_interrupt, 0);
        check("mid_rst_rdata", io_rdata, 0);
        check("mid_rst_code", int_code, 0);
        check("mid_rst_mip", mip_bits, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd(3'd3);
        check("rst_cmp_hi", io_rdata, 32'hFFFF_FFFF);
        rd(3'd2);
        check("rst_cmp_lo", io_rdata, 32'hFFFF_FFFF);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) ext_int_in = ~ext_int_in;
            csr_rmie    = ($urandom_range(0, 3) != 0);
            csr_meie    = 1'($urandom_range(0, 1));
            csr_mtie    = 1'($urandom_range(0, 1));
            csr_msie    = 1'($urandom_range(0, 1));
            stall       = ($urandom_range(0, 3) == 0);
            cmd_mret_ex = ($urandom_range(0, 7) == 0);
            io_we       = ($urandom_range(0, 7) == 0);
            io_re       = ($urandom_range(0, 2) == 0);
            io_adr      = 3'($urandom_range(0, 7));
            io_wdata    = ($urandom_range(0, 1) == 1) ? $urandom
                                                      : 32'($urandom_range(0, 64));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
